// File: rtl/maindec_mc.sv
// Multicycle LEGv8 main control: sequences fetch/decode/execute/memory/write-back,
// with memory-ready stalls, optional CBNZ, sticky illegal-opcode trap and retire counter.
module maindec_mc #(
    parameter bit          EN_CBNZ = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      Op,
    input  logic             mem_ready,
    output logic             Reg2Loc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNZ,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StAluWb    = 4'd7,
        StBranch   = 4'd8,
        StIllegal  = 4'd15
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q;
    logic             retire;

    logic is_ldur, is_stur, is_cbz, is_cbnz_raw, is_cbnz, is_rtype;

    assign is_ldur     = (Op == 11'b11111000010);
    assign is_stur     = (Op == 11'b11111000000);
    assign is_cbz      = (Op[10:3] == 8'b10110100);
    assign is_cbnz_raw = (Op[10:3] == 8'b10110101);
    assign is_cbnz     = is_cbnz_raw && EN_CBNZ;
    assign is_rtype    = (Op == 11'b10001011000) || (Op == 11'b11001011000) ||
                         (Op == 11'b10001010000) || (Op == 11'b10101010000);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (state_d == StIllegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        Reg2Loc     = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNZ    = 1'b0;

        case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                // Branch target PC + (imm << 2) is computed speculatively here.
                ALUSrcB = 2'b11;
                Reg2Loc = is_stur || is_cbz || is_cbnz_raw;
                if (is_ldur || is_stur)     state_d = StMemAdr;
                else if (is_rtype)          state_d = StExecute;
                else if (is_cbz || is_cbnz) state_d = StBranch;
                else                        state_d = StIllegal;
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                Reg2Loc = is_stur;
                state_d = is_ldur ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StMemWrite: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                Reg2Loc  = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExecute: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                Reg2Loc     = 1'b1;
                PCWriteCond = 1'b1;
                BranchNZ    = is_cbnz;
                retire      = 1'b1;
                state_d     = StFetch;
            end
            StIllegal: begin
                state_d = StIllegal;
            end
            default: begin
                state_d = StIllegal;
            end
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign illegal = illegal_q;

endmodule
